// File: rtl/ex_forward_hazard_ctrl_pkg.sv
// Shared types for the execute-stage forwarding/hazard controller:
// forward-select codes and the scoreboard slot record.
package ex_forward_hazard_ctrl_pkg;

  localparam int REG_W = 3;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t SEL_MUX = 2'b00;  // no forward, operand mux path
  localparam fwd_sel_t SEL_WB  = 2'b01;  // write-back value (load or M/W)
  localparam fwd_sel_t SEL_EM  = 2'b10;  // ALU result leaving execute
  localparam fwd_sel_t SEL_MW  = 2'b11;  // ALU result one stage further on

  typedef struct packed {
    logic             v;
    logic             wr;
    logic             ld;
    logic [REG_W-1:0] dst;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/ex_fwd_sel_logic.sv
// Match and priority encoder producing the forward select for one operand,
// nearest in-flight producer first.
module ex_fwd_sel_logic
  import ex_forward_hazard_ctrl_pkg::*;
#(
  parameter bit ALLOW_MW = 1'b1
) (
  input  logic             valid,
  input  logic             used,
  input  logic [REG_W-1:0] idx,
  input  slot_t            e_slot,
  input  slot_t            m_slot,
  output fwd_sel_t         sel
);

  logic e_hit;
  logic m_hit;
  logic unused_e_ld;

  // A load in E never gets here: the hazard check stalls it first.
  assign unused_e_ld = e_slot.ld;

  assign e_hit = valid & used & e_slot.v & e_slot.wr & (e_slot.dst == idx);
  assign m_hit = valid & used & m_slot.v & m_slot.wr & (m_slot.dst == idx);

  always_comb begin
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = SEL_MUX;
    if (e_hit) begin
      sel = SEL_EM;
    end else if (m_hit) begin
      sel = (ALLOW_MW && !m_slot.ld) ? SEL_MW : SEL_WB;
    end
  end

endmodule

// File: rtl/ex_forward_hazard_ctrl.sv
// Execute-stage sequencing: in-flight destination scoreboard, registered
// operand-forward selects, load-use bubble insertion, freeze and flush.
module ex_forward_hazard_ctrl
  import ex_forward_hazard_ctrl_pkg::*;
#(
  parameter int RW          = REG_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   d_valid,
  input  logic [RW-1:0]          d_src,
  input  logic [RW-1:0]          d_dst,
  input  logic                   d_src_used,
  input  logic                   d_dst_used,
  input  logic                   d_wr_reg,
  input  logic                   d_is_load,
  input  logic                   freeze,
  input  logic                   flush,
  output logic [1:0]             FU_Src_Sel,
  output logic [1:0]             FU_Dst_Sel,
  output logic                   stall_fd,
  output logic                   bubble_ex,
  output logic [STALL_CNT_W-1:0] stall_count
);

  if (RW != REG_W) begin : g_rw_check
    $error("RW must equal the slot record index width");
  end

  slot_t    e_q, m_q, w_q;
  fwd_sel_t src_sel_c, dst_sel_c;
  logic     lu;
  logic     unused_w;

  // W is kept for pipeline bookkeeping only; no select looks that far back.
  assign unused_w = ^w_q;

  assign lu = e_q.v & e_q.ld & e_q.wr & d_valid &
              ((d_src_used & (d_src == e_q.dst)) |
               (d_dst_used & (d_dst == e_q.dst)));

  assign stall_fd = lu & ~freeze & ~flush;

  ex_fwd_sel_logic #(.ALLOW_MW(1'b1)) u_sel_a (
    .valid  (d_valid),
    .used   (d_src_used),
    .idx    (d_src),
    .e_slot (e_q),
    .m_slot (m_q),
    .sel    (src_sel_c)
  );

  ex_fwd_sel_logic #(.ALLOW_MW(1'b0)) u_sel_b (
    .valid  (d_valid),
    .used   (d_dst_used),
    .idx    (d_dst),
    .e_slot (e_q),
    .m_slot (m_q),
    .sel    (dst_sel_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking so every slot shifts from its pre-edge value.
    if (!rst) begin
      e_q         <= SLOT_BUBBLE;
      m_q         <= SLOT_BUBBLE;
      w_q         <= SLOT_BUBBLE;
      FU_Src_Sel  <= SEL_MUX;
      FU_Dst_Sel  <= SEL_MUX;
      bubble_ex   <= 1'b1;
      stall_count <= '0;
    end else if (!freeze) begin
      w_q <= m_q;
      m_q <= e_q;
      if (flush) begin
        e_q        <= SLOT_BUBBLE;
        FU_Src_Sel <= SEL_MUX;
        FU_Dst_Sel <= SEL_MUX;
        bubble_ex  <= 1'b1;
      end else if (lu) begin
        e_q        <= SLOT_BUBBLE;
        FU_Src_Sel <= SEL_MUX;
        FU_Dst_Sel <= SEL_MUX;
        bubble_ex  <= 1'b1;
        if (stall_count != '1) begin
          stall_count <= stall_count + STALL_CNT_W'(1);
        end
      end else begin
        e_q        <= '{v: d_valid, wr: d_wr_reg, ld: d_is_load, dst: d_dst};
        FU_Src_Sel <= src_sel_c;
        FU_Dst_Sel <= dst_sel_c;
        bubble_ex  <= ~d_valid;
      end
    end
  end

endmodule

// File: doc/ex_forward_hazard_ctrl.md
Name: ex_forward_hazard_ctrl

Overview:
- Sequencing controller for the execute stage.
- Keeps its own scoreboard of the in-flight destination registers in the E/M and M/W slots.
- Produces registered operand-forwarding selects (FU_Src_Sel, FU_Dst_Sel) for the instruction entering execute.
- Detects load-use hazards and inserts a one-cycle bubble while stalling fetch/decode; also handles pipeline freeze and branch flush.

Parameters:
- RW, 3, register-index width (8 GPRs).
- STALL_CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- d_valid  in  1  decode holds a real instruction
- d_src  in  RW  source register index of the decode instruction
- d_dst  in  RW  destination register index of the decode instruction
- d_src_used  in  1  operand A reads d_src (low when the A mux picks IN/Imm/SP)
- d_dst_used  in  1  operand B reads d_dst (low when the B mux picks shamt)
- d_wr_reg  in  1  decode instruction writes d_dst
- d_is_load  in  1  decode instruction is a memory read
- freeze  in  1  global hold (memory busy)
- flush  in  1  branch taken; kill the decode instruction
- FU_Src_Sel  out  2  operand-A select for the EX stage
- FU_Dst_Sel  out  2  operand-B select for the EX stage
- stall_fd  out  1  hold PC and IF/ID this cycle (combinational)
- bubble_ex  out  1  registered; instruction now in EX is a bubble
- stall_count  out  STALL_CNT_W  number of load-use stalls, saturating

Behaviour:
- Scoreboard slots E, M, W. Each slot holds {v, wr, ld, dst}.
  - E is the instruction currently in execute, M is one ahead, W is two ahead.
- Reset (rst=0, asynchronous):
  - all slot v=0; FU_Src_Sel=00; FU_Dst_Sel=00; bubble_ex=1; stall_count=0.
- Hazard (combinational):
  - lu = E.v & E.ld & E.wr & d_valid & ((d_src_used & d_src==E.dst) | (d_dst_used & d_dst==E.dst)).
- stall_fd = lu & ~freeze & ~flush.
- Update at each rising edge, first matching rule in this order:
  - freeze=1: all slots and outputs hold.
  - otherwise W<=M and M<=E, then:
    - flush=1: E<=bubble (v=0); selects<=00; bubble_ex<=1. flush overrides lu, and stall_fd=0.
    - lu=1: E<=bubble; selects<=00; bubble_ex<=1; stall_count+=1 (saturate at all-ones). Decode is held, so the same instruction is re-evaluated next cycle with the load now in M.
    - else: E<={d_valid, d_wr_reg, d_is_load, d_dst}; bubble_ex<=~d_valid; selects computed as below.
- Select encoding for operand A (FU_Src_Sel), taking the nearest producer first:
  - match in current E slot (becomes M, i.e. ALU_After_E_M): 10. A load cannot reach this case because lu would have stalled.
  - else match in current M slot (becomes W): 01 (WB) if that producer is a load, 11 (ALU_M_W) if it is an ALU op.
  - else 00.
- Select encoding for operand B (FU_Dst_Sel): E-slot match gives 10; M-slot match gives 01 for any producer; else 00. Code 11 is never driven on B.
- Match definition: slot v & wr & index equal & the corresponding *_used=1.
- Latency: selects are registered with 1 cycle of latency. They are valid for the whole cycle the instruction sits in EX and are stable through a freeze.
- Edge cases:
  - d_valid=0 gives selects 00.
  - Index compares are exact; register 0 is a normal register.
  - Stall during freeze: neither stall_count nor the slots change.
  - Reset mid-stall: drops the bubble and leaves decode unheld (stall_fd=0 because E.v=0).

Decomposition:
- Shared package/header holds:
  - select constants SEL_MUX=00, SEL_WB=01, SEL_EM=10, SEL_MW=11;
  - the slot record layout {v, wr, ld, dst[RW-1:0]}.
- One natural sub-module: ex_fwd_sel_logic.
  - Combinational match/priority encoder for a single operand.
  - Instantiated twice, with an allow_mw flag set on the A instance and cleared on the B instance.

Test Plan:
- Reset then idle: rst low mid-cycle → outputs 00/00, bubble_ex=1, stall_count=0 immediately.
- ADD R1 then ADD R2 with src=R1 (back-to-back) → second instruction in EX sees FU_Src_Sel=10. With one independent instruction between them → 11. When the producer is a load two ahead → 01.
- LDD R3 followed by an instruction with dst=R3 (dst_used=1):
  - one cycle with stall_fd=1, then bubble_ex=1;
  - next cycle FU_Dst_Sel=01;
  - stall_count=1.
- Load-use with flush asserted in the same cycle → stall_fd=0, E becomes a bubble, stall_count unchanged.
- freeze held 3 cycles with a pending forward of 10 → selects stay 10 and slots are unchanged; after release, the pipeline advances normally.
- Shift (d_dst_used=0) matching the E-slot producer → FU_Dst_Sel=00. Force stall_count to all-ones and trigger a stall → count stays saturated.
